// File: rtl/mem_serdes_pkg.sv
// Shared types and elaboration helpers for the memory-bus serializer.
// Holds the transaction state encoding and the beat/counter sizing functions.
package mem_serdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int beatCount(input int width, input int pinW);
        return width / pinW;
    endfunction

    // Bits needed for a counter that runs 0..maxCount-1, never narrower than one bit.
    function automatic int cntWidth(input int maxCount);
        return (maxCount <= 2) ? 1 : $clog2(maxCount);
    endfunction

endpackage

// File: rtl/mem_serdes_shifter.sv
// PIN_W-wide slice shift register: loads a full word, then retires one beat per shift
// from the bottom while a new beat enters at the top.
module mem_serdes_shifter #(
    parameter int WIDTH = 32,
    parameter int PIN_W = 4,
    parameter int TOP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadData,
    input  logic             i_shift,
    input  logic [PIN_W-1:0] i_shiftIn,
    output logic [PIN_W-1:0] o_beat,
    output logic [TOP_W-1:0] o_topNext
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next;

    assign w_next = {i_shiftIn, r_data[WIDTH-1:PIN_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_loadData;
        end else if (i_shift) begin
            r_data <= w_next;
        end
    end

    assign o_beat = r_data[PIN_W-1:0];

    // Top slots of the post-shift word, so the final inbound beat is included in the same cycle.
    assign o_topNext = w_next[WIDTH-1 -: TOP_W];

endmodule

// File: rtl/mem_bus_serdes.sv
// Serializes core read/write transactions onto a narrow pin bus and assembles read data
// from inbound beats, with an idle-beat timeout on the read wait.
module mem_bus_serdes
    import mem_serdes_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int PIN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_adr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_busy,
    output logic              core_ack,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rdata,
    output logic              pin_frame,
    output logic              pin_we,
    output logic [PIN_W-1:0]  pin_out,
    input  logic [PIN_W-1:0]  pin_in,
    input  logic              pin_in_valid
);

    localparam int A    = beatCount(ADDR_W, PIN_W);
    localparam int D    = beatCount(DATA_W, PIN_W);
    localparam int MAXB = (A > D) ? A : D;
    localparam int BCW  = cntWidth(MAXB);
    localparam int ICW  = cntWidth(TIMEOUT);

    localparam logic [BCW-1:0] A_LAST = BCW'(A - 1);
    localparam logic [BCW-1:0] D_LAST = BCW'(D - 1);
    localparam logic [ICW-1:0] T_LAST = ICW'(TIMEOUT - 1);

    generate
        if ((PIN_W < 1) || (ADDR_W % PIN_W != 0) || (DATA_W % PIN_W != 0) || (TIMEOUT < 1)) begin : g_badParams
            $fatal(1, "mem_bus_serdes: ADDR_W/DATA_W must be multiples of PIN_W and TIMEOUT >= 1");
        end
    endgenerate

    state_t            r_state;
    logic              r_we;
    logic              r_err;
    logic [BCW-1:0]    r_beat;
    logic [ICW-1:0]    r_idle;
    logic [DATA_W-1:0] r_rdata;

    logic              w_frame;
    logic              w_load;
    logic              w_shift;
    logic [PIN_W-1:0]  w_beat;
    logic [DATA_W-1:0] w_assembled;

    assign w_frame = (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_load  = (r_state == ST_IDLE) && core_req;
    assign w_shift = w_frame || ((r_state == ST_RWAIT) && pin_in_valid);

    // One shared register carries {wdata, adr} out and collects inbound beats into its top slots.
    mem_serdes_shifter #(
        .WIDTH (ADDR_W + DATA_W),
        .PIN_W (PIN_W),
        .TOP_W (DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_loadData ({core_wdata, core_adr}),
        .i_shift    (w_shift),
        .i_shiftIn  (pin_in),
        .o_beat     (w_beat),
        .o_topNext  (w_assembled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_idle  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (core_req) begin
                        r_we    <= core_we;
                        r_beat  <= '0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (r_beat == A_LAST) begin
                        r_beat  <= '0;
                        r_idle  <= '0;
                        r_state <= r_we ? ST_WDATA : ST_RWAIT;
                    end else begin
                        r_beat <= r_beat + BCW'(1);
                    end
                end
                ST_WDATA: begin
                    if (r_beat == D_LAST) begin
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_beat <= r_beat + BCW'(1);
                    end
                end
                ST_RWAIT: begin
                    if (pin_in_valid) begin
                        r_idle <= '0;
                        if (r_beat == D_LAST) begin
                            r_rdata <= w_assembled;
                            r_err   <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat <= r_beat + BCW'(1);
                        end
                    end else if (r_idle == T_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idle <= r_idle + ICW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_busy  = (r_state != ST_IDLE);
    assign core_ack   = (r_state == ST_DONE);
    assign core_err   = (r_state == ST_DONE) && r_err;
    assign core_rdata = r_rdata;
    assign pin_frame  = w_frame;
    assign pin_we     = w_frame && r_we;
    assign pin_out    = w_frame ? w_beat : '0;

endmodule

// File: tb/tb_mem_bus_serdes.sv
// Randomized self-checking bench for mem_bus_serdes: two configurations, one transaction
// model computing beats, ack timing, error and read data from the transfer rules.
module tb_mem_bus_serdes;

    localparam int T0 = 8;
    localparam int T1 = 64;

    logic        clk;
    logic        rstN;
    logic        req;
    logic        we;
    logic [15:0] adr;
    logic [31:0] wdata;
    logic [7:0]  pinIn;
    logic        pinInValid;
    logic        sel;

    logic        busy0, ack0, err0, frame0, pinWe0;
    logic [15:0] rdata0;
    logic [3:0]  pinOut0;
    logic        busy1, ack1, err1, frame1, pinWe1;
    logic [31:0] rdata1;
    logic [7:0]  pinOut1;

    logic        obsBusy, obsAck, obsErr, obsFrame, obsPinWe;
    logic [7:0]  obsPinOut;
    logic [31:0] obsRdata;

    int          checkCount;
    int          errorCount;
    logic [31:0] modelRdata [2];
    int          planGaps [4];
    logic [7:0]  planBeats [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_serdes #(.ADDR_W(16), .DATA_W(16), .PIN_W(4), .TIMEOUT(T0)) dut0 (
        .clk(clk), .reset(rstN), .core_req(req && !sel), .core_we(we), .core_adr(adr),
        .core_wdata(wdata[15:0]), .core_busy(busy0), .core_ack(ack0), .core_err(err0),
        .core_rdata(rdata0), .pin_frame(frame0), .pin_we(pinWe0), .pin_out(pinOut0),
        .pin_in(pinIn[3:0]), .pin_in_valid(pinInValid)
    );

    mem_bus_serdes #(.ADDR_W(16), .DATA_W(32), .PIN_W(8), .TIMEOUT(T1)) dut1 (
        .clk(clk), .reset(rstN), .core_req(req && sel), .core_we(we), .core_adr(adr),
        .core_wdata(wdata), .core_busy(busy1), .core_ack(ack1), .core_err(err1),
        .core_rdata(rdata1), .pin_frame(frame1), .pin_we(pinWe1), .pin_out(pinOut1),
        .pin_in(pinIn), .pin_in_valid(pinInValid)
    );

    assign obsBusy   = sel ? busy1  : busy0;
    assign obsAck    = sel ? ack1   : ack0;
    assign obsErr    = sel ? err1   : err0;
    assign obsFrame  = sel ? frame1 : frame0;
    assign obsPinWe  = sel ? pinWe1 : pinWe0;
    assign obsPinOut = sel ? pinOut1 : {4'h0, pinOut0};
    assign obsRdata  = sel ? rdata1  : {16'h0, rdata0};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (dut%0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, " busy"},   32'(obsBusy),   32'd0);
        checkOutput({tag, " ack"},    32'(obsAck),    32'd0);
        checkOutput({tag, " err"},    32'(obsErr),    32'd0);
        checkOutput({tag, " frame"},  32'(obsFrame),  32'd0);
        checkOutput({tag, " pinWe"},  32'(obsPinWe),  32'd0);
        checkOutput({tag, " pinOut"}, 32'(obsPinOut), 32'd0);
        checkOutput({tag, " rdata"},  obsRdata,       modelRdata[sel]);
    endtask

    task automatic checkIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkQuiet("idle");
            @(posedge clk);
            #1;
        end
    endtask

    // One transaction, entered at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
    task automatic applyStimulus(input logic isWrite, input logic [15:0] a, input logic [31:0] wd,
                                 input logic holdReq);
        int          pw, aBeats, dBeats, tmo, ackCycle, cur;
        logic        expErr, expFrame;
        int          validAt [4];
        logic [63:0] mask, expBeat;
        logic [31:0] newRdata;

        pw     = sel ? 8 : 4;
        aBeats = 16 / pw;
        dBeats = (sel ? 32 : 16) / pw;
        tmo    = sel ? T1 : T0;
        mask   = (64'd1 << pw) - 64'd1;
        expErr = 1'b0;
        newRdata = '0;
        for (int i = 0; i < 4; i++) validAt[i] = -1;

        if (isWrite) begin
            ackCycle = aBeats + dBeats + 1;
        end else begin
            cur = aBeats + 1;
            ackCycle = -1;
            for (int i = 0; i < dBeats; i++) begin
                if (planGaps[i] >= tmo) begin
                    ackCycle = cur + tmo;
                    expErr = 1'b1;
                    break;
                end
                validAt[i] = cur + planGaps[i];
                cur = validAt[i] + 1;
                newRdata = newRdata | ((32'(planBeats[i]) & mask[31:0]) << (i * pw));
            end
            if (!expErr) ackCycle = cur;
        end

        req = 1'b1;
        we = isWrite;
        adr = a;
        wdata = wd;
        pinInValid = 1'b0;
        pinIn = 8'($urandom);
        @(negedge clk);
        checkOutput("preBusy", 32'(obsBusy), 32'd0);
        checkOutput("preAck", 32'(obsAck), 32'd0);
        @(posedge clk);
        #1;

        for (int c = 1; c <= ackCycle; c++) begin
            req = holdReq ? 1'b1 : 1'($urandom);
            we = 1'($urandom);
            adr = 16'($urandom);
            wdata = $urandom;
            pinIn = 8'($urandom);
            pinInValid = 1'($urandom);
            if (!isWrite && c > aBeats && c < ackCycle) begin
                pinInValid = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (validAt[i] == c) begin
                        pinInValid = 1'b1;
                        pinIn = planBeats[i];
                    end
                end
            end
            @(negedge clk);
            expFrame = (c <= aBeats) || (isWrite && c <= aBeats + dBeats);
            if (c <= aBeats) expBeat = (64'(a) >> ((c - 1) * pw)) & mask;
            else if (expFrame) expBeat = (64'(wd) >> ((c - aBeats - 1) * pw)) & mask;
            else expBeat = '0;
            checkOutput($sformatf("busy c%0d", c), 32'(obsBusy), 32'd1);
            checkOutput($sformatf("frame c%0d", c), 32'(obsFrame), 32'(expFrame));
            checkOutput($sformatf("pinOut c%0d", c), 32'(obsPinOut), expBeat[31:0]);
            checkOutput($sformatf("pinWe c%0d", c), 32'(obsPinWe), 32'(expFrame && isWrite));
            checkOutput($sformatf("ack c%0d", c), 32'(obsAck), 32'(c == ackCycle));
            checkOutput($sformatf("err c%0d", c), 32'(obsErr), 32'((c == ackCycle) && expErr));
            checkOutput($sformatf("rdata c%0d", c), obsRdata,
                        (c == ackCycle && !isWrite && !expErr) ? newRdata : modelRdata[sel]);
            @(posedge clk);
            #1;
        end

        if (!isWrite && !expErr) modelRdata[sel] = newRdata;
        if (!holdReq) req = 1'b0;
        pinInValid = 1'b0;
    endtask

    // Reset lands in the third address beat; outputs must collapse before the next edge.
    task automatic applyMidReset();
        sel = 1'b0;
        req = 1'b1;
        we = 1'b1;
        adr = 16'($urandom);
        wdata = $urandom;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("preRst frame", 32'(obsFrame), 32'd1);
        #1;
        rstN = 1'b0;
        modelRdata[0] = '0;
        modelRdata[1] = '0;
        #1;
        checkQuiet("midRst");
        repeat (3) begin
            @(negedge clk);
            checkQuiet("inRst");
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        int  chain;
        int  tmo;
        int  r;
        logic isW;

        checkCount = 0;
        errorCount = 0;
        modelRdata[0] = '0;
        modelRdata[1] = '0;
        sel = 1'b0;
        req = 1'b0;
        we = 1'b0;
        adr = '0;
        wdata = '0;
        pinIn = '0;
        pinInValid = 1'b0;
        rstN = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkQuiet("reset0");
        sel = 1'b1;
        #1;
        checkQuiet("reset1");
        sel = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkIdle(1);

        for (int i = 0; i < 4; i++) planGaps[i] = 0;
        applyStimulus(1'b1, 16'h1234, 32'h0000BEEF, 1'b0);

        planBeats[0] = 8'h0D; planBeats[1] = 8'h0A; planBeats[2] = 8'h0E; planBeats[3] = 8'h0D;
        planGaps[0] = 0; planGaps[1] = 2; planGaps[2] = 0; planGaps[3] = 1;
        applyStimulus(1'b0, 16'h00A5, 32'h0, 1'b0);
        checkOutput("read DEAD", obsRdata, 32'h0000DEAD);

        planGaps[0] = T0; planGaps[1] = 0; planGaps[2] = 0; planGaps[3] = 0;
        applyStimulus(1'b0, 16'h5A5A, 32'h0, 1'b0);
        checkOutput("timeout keeps DEAD", obsRdata, 32'h0000DEAD);

        for (int i = 0; i < 4; i++) planBeats[i] = 8'($urandom);
        planGaps[0] = T0 - 1; planGaps[1] = 0; planGaps[2] = T0 - 1; planGaps[3] = 3;
        applyStimulus(1'b0, 16'hC3C3, 32'h0, 1'b0);

        applyStimulus(1'b1, 16'hA1B2, 32'h0000C3D4, 1'b1);
        applyStimulus(1'b1, 16'h1357, 32'h00002468, 1'b0);
        checkIdle(3);

        applyMidReset();
        checkIdle(1);
        applyStimulus(1'b1, 16'h0F0F, 32'h0000F00D, 1'b0);

        sel = 1'b1;
        checkIdle(1);
        for (int i = 0; i < 4; i++) planGaps[i] = 0;
        applyStimulus(1'b1, 16'hABCD, 32'h12345678, 1'b0);
        for (int i = 0; i < 4; i++) planBeats[i] = 8'($urandom);
        planGaps[1] = 2;
        applyStimulus(1'b0, 16'h4321, 32'h0, 1'b0);
        planGaps[0] = 1; planGaps[1] = T1; planGaps[2] = 0; planGaps[3] = 0;
        applyStimulus(1'b0, 16'h8765, 32'h0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            sel = 1'($urandom);
            tmo = sel ? T1 : T0;
            chain = $urandom_range(1, 3);
            for (int k = 0; k < chain; k++) begin
                isW = 1'($urandom);
                for (int i = 0; i < 4; i++) begin
                    r = $urandom_range(0, 19);
                    planGaps[i] = (r < 15) ? (r % 3) : ((r < 18) ? tmo - 1 : tmo);
                    planBeats[i] = 8'($urandom);
                end
                applyStimulus(isW, 16'($urandom), $urandom, k < chain - 1);
            end
            checkIdle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
